// File: rtl/drum_audio_bridge.sv
// Paces the drum solver at the audio rate and turns centre-node samples into 32-bit audio words.
// Latency: step_done -> audio_valid 1 cycle when empty; pacer tick -> step_start 1 cycle minimum.
// Backpressure: full FIFO holds off new step requests; surplus samples are dropped and counted.
`timescale 1ns/1ps
module drum_audio_bridge #(
    parameter int SAMPLE_DIV = 1041,
    parameter int DEPTH      = 8,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   step_busy,
    input  logic                   step_done,
    input  logic [17:0]            u_center,
    output logic                   step_start,
    output logic [31:0]            audio_data,
    output logic                   audio_valid,
    input  logic                   audio_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            drop_count,
    output logic [15:0]            miss_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int SH = 14 + GAIN_SHIFT;
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] div_cnt;
    logic          req_pending;
    logic          in_flight;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem [DEPTH];

    logic signed [63:0] wide;
    logic [31:0]   sample;
    logic          tick;
    logic          issue;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [AW-1:0] rd_next;
    logic [AW:0]   cnt_next;
    logic [31:0]   head_next;

    // Shift in a wide container so overflow is visible before clamping to 32 bits.
    always_comb begin
        wide = {{46{u_center[17]}}, u_center};
        wide = wide <<< SH;
        if (wide > 64'sh7FFF_FFFF)
            sample = 32'h7FFF_FFFF;
        else if (wide < -64'sh8000_0000)
            sample = 32'h8000_0000;
        else
            sample = wide[31:0];
    end

    always_comb begin
        tick     = enable && (div_cnt == DIV_LAST);
        full     = (fifo_count == FULL_CNT);
        issue    = req_pending && !step_busy && !in_flight && !full;
        pop      = audio_valid && audio_ready;
        push     = step_done && (!full || pop);
        drop     = step_done && full && !pop;
        rd_next  = rd_ptr + AW'(pop);
        cnt_next = fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
        // The incoming word becomes the head when it lands exactly where the read pointer goes next.
        head_next = (push && (wr_ptr == rd_next)) ? sample : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            req_pending <= 1'b0;
            in_flight   <= 1'b0;
            step_start  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            audio_valid <= 1'b0;
            audio_data  <= '0;
            drop_count  <= '0;
            miss_count  <= '0;
        end else begin
            if (!enable || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            if (tick)
                req_pending <= 1'b1;
            else if (issue)
                req_pending <= 1'b0;

            // A tick is only lost if the earlier request is not being consumed on this edge.
            if (tick && req_pending && !issue && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;

            step_start <= issue;

            if (issue)
                in_flight <= 1'b1;
            else if (step_done)
                in_flight <= 1'b0;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr      <= rd_next;
            fifo_count  <= cnt_next;
            audio_valid <= (cnt_next != '0);
            audio_data  <= head_next;

            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_drum_audio_bridge.sv
// Directed bench for drum_audio_bridge: pacing, conversion, FIFO full/drop, busy misses and reset.
`timescale 1ns/1ps
module tb_drum_audio_bridge;
    localparam int SD = 4;
    localparam int DP = 8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        step_busy;
    logic        step_done;
    logic [17:0] u_center;
    logic        audio_ready;

    logic        step_start;
    logic [31:0] audio_data;
    logic        audio_valid;
    logic [3:0]  fifo_count;
    logic [15:0] drop_count;
    logic [15:0] miss_count;

    logic        step_start_g2;
    logic [31:0] audio_data_g2;
    logic        audio_valid_g2;
    logic [3:0]  fifo_count_g2;
    logic [15:0] drop_count_g2;
    logic [15:0] miss_count_g2;

    int checks = 0;
    int failures = 0;
    int dly, nstart, first_start, last_start, bad_gap, first_valid, found;

    logic [17:0] cu  [6] = '{18'h04000, 18'h3C000, 18'h1FFFF, 18'h10000, 18'h30000, 18'h20000};
    logic [31:0] ce0 [6] = '{32'h1000_0000, 32'hF000_0000, 32'h7FFF_C000,
                             32'h4000_0000, 32'hC000_0000, 32'h8000_0000};
    logic [31:0] ce2 [6] = '{32'h4000_0000, 32'hC000_0000, 32'h7FFF_FFFF,
                             32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};

    drum_audio_bridge #(.SAMPLE_DIV(SD), .DEPTH(DP), .GAIN_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .step_busy(step_busy),
        .step_done(step_done), .u_center(u_center), .step_start(step_start),
        .audio_data(audio_data), .audio_valid(audio_valid), .audio_ready(audio_ready),
        .fifo_count(fifo_count), .drop_count(drop_count), .miss_count(miss_count)
    );

    drum_audio_bridge #(.SAMPLE_DIV(SD), .DEPTH(DP), .GAIN_SHIFT(2)) dut_g2 (
        .clk(clk), .reset(reset), .enable(enable), .step_busy(step_busy),
        .step_done(step_done), .u_center(u_center), .step_start(step_start_g2),
        .audio_data(audio_data_g2), .audio_valid(audio_valid_g2), .audio_ready(audio_ready),
        .fifo_count(fifo_count_g2), .drop_count(drop_count_g2), .miss_count(miss_count_g2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; step_busy = 1'b0; step_done = 1'b0;
        u_center = '0; audio_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; step_busy = 1'b0; step_done = 1'b0;
        u_center = '0; audio_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_step_start", 32'(step_start), 0);
        chk("rst_valid", 32'(audio_valid), 0);
        chk("rst_data", audio_data, 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_miss", 32'(miss_count), 0);

        // Conversion at both gains, one word in and out per vector
        for (int i = 0; i < 6; i++) begin
            step_done = 1'b1; u_center = cu[i];
            cyc();
            step_done = 1'b0;
            chk($sformatf("conv_g0_%0d", i), audio_data, ce0[i]);
            chk($sformatf("conv_g2_%0d", i), audio_data_g2, ce2[i]);
            chk($sformatf("conv_valid_%0d", i), 32'(audio_valid), 1);
            audio_ready = 1'b1;
            cyc();
            audio_ready = 1'b0;
            chk($sformatf("conv_empty_%0d", i), 32'(fifo_count), 0);
        end

        // Steady pacing with a solver answering 3 cycles after each start
        do_reset();
        enable = 1'b1; audio_ready = 1'b1; u_center = 18'h04000;
        dly = 0; nstart = 0; first_start = -1; last_start = -1; bad_gap = 0; first_valid = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (step_start) begin
                if (first_start < 0) first_start = c;
                else if (c - last_start != SD) bad_gap++;
                last_start = c;
                nstart++;
                dly = 3;
            end
            if (audio_valid && first_valid < 0) first_valid = c;
            step_done = 1'b0;
            if (dly != 0) begin
                dly--;
                if (dly == 0) step_done = 1'b1;
            end
        end
        step_done = 1'b0;
        chk("pace_first_start", first_start, SD + 1);
        chk("pace_nstart", nstart, 9);
        chk("pace_bad_gap", bad_gap, 0);
        chk("pace_first_valid", first_valid, SD + 1 + 3);
        chk("pace_miss", 32'(miss_count), 0);
        chk("pace_drop", 32'(drop_count), 0);

        // Ten samples into a stalled FIFO of eight
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step_done = 1'b1; u_center = 18'(k << 8);
            cyc();
        end
        step_done = 1'b0;
        chk("full_count", 32'(fifo_count), DP);
        chk("full_drop", 32'(drop_count), 2);
        chk("full_valid", 32'(audio_valid), 1);
        enable = 1'b1; nstart = 0;
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (step_start) nstart++;
        end
        chk("full_no_start", nstart, 0);
        enable = 1'b0; audio_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_word_%0d", k), audio_data, 32'(k << 22));
            cyc();
        end
        audio_ready = 1'b0;
        chk("drain_valid", 32'(audio_valid), 0);
        chk("drain_count", 32'(fifo_count), 0);

        // Push and pop together on a full FIFO
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step_done = 1'b1; u_center = 18'(k << 8);
            cyc();
        end
        step_done = 1'b1; u_center = 18'(9 << 8); audio_ready = 1'b1;
        cyc();
        step_done = 1'b0;
        chk("pp_count", 32'(fifo_count), DP);
        chk("pp_drop", 32'(drop_count), 0);
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("pp_word_%0d", k), audio_data, 32'(k << 22));
            cyc();
        end
        audio_ready = 1'b0;
        chk("pp_empty", 32'(fifo_count), 0);

        // Solver busy across three pacer periods
        do_reset();
        enable = 1'b1; step_busy = 1'b1; nstart = 0;
        for (int c = 0; c < 3 * SD; c++) begin
            cyc();
            if (step_start) nstart++;
        end
        chk("busy_miss", 32'(miss_count), 2);
        chk("busy_no_start", nstart, 0);
        step_busy = 1'b0; nstart = 0; first_start = -1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (step_start) begin
                nstart++;
                if (first_start < 0) first_start = c;
            end
        end
        chk("busy_one_start", nstart, 1);
        chk("busy_start_at", first_start, 1);
        chk("busy_miss_hold", 32'(miss_count), 2);

        // Reset right after a step_start, with a step_done in the reset cycle
        do_reset();
        enable = 1'b1;
        step_done = 1'b1; u_center = 18'h04000;
        cyc();
        step_done = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (step_start) found = 1;
            else cyc();
        end
        chk("mid_start_seen", found, 1);
        chk("mid_count_pre", 32'(fifo_count), 1);
        reset = 1'b1; step_done = 1'b1; u_center = 18'h1FFFF;
        cyc();
        reset = 1'b0; step_done = 1'b0;
        chk("mid_rst_start", 32'(step_start), 0);
        chk("mid_rst_valid", 32'(audio_valid), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_data", audio_data, 0);
        first_start = -1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (step_start && first_start < 0) first_start = c;
        end
        chk("mid_first_start", first_start, SD + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
